// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum stage is controlled by IMEM_LOADER_CSUM_EN (see imem_loader.sv).
package imem_loader_pkg;

   localparam int IMEM_DEPTH = 64;
   localparam int BYTE_W     = 8;
   localparam int WORD_W     = 32;

   // Loader sequencing; CSUM is only reachable when the checksum stage is built in.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      DONE = 3'd4
   } state_e;

   // Drop one byte into its little-endian lane of a 32-bit word.
   function automatic logic [WORD_W-1:0] place_byte(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        idx,
                                                    input logic [BYTE_W-1:0] b);
      logic [WORD_W-1:0] r;
      r = word;
      r[idx*BYTE_W +: BYTE_W] = b;
      return r;
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler. word_o/word_valid_o are combinational so the
// caller can register the completed word on the same edge the fourth byte arrives.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              byte_valid_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o
);

   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [WORD_W-1:0] partial_q, partial_d;

   // Merge the incoming byte into the partial word and advance the lane index.
   always_comb begin
      word_o       = place_byte(partial_q, byte_idx_q, byte_i);
      word_valid_o = byte_valid_i && (byte_idx_q == 2'd3);
      partial_d    = partial_q;
      byte_idx_d   = byte_idx_q;
      if (clear_i) begin
         partial_d  = '0;
         byte_idx_d = '0;
      end else if (byte_valid_i) begin
         byte_idx_d = byte_idx_q + 2'd1;
         partial_d  = word_valid_o ? '0 : word_o;
      end
   end

   // Partial word and lane index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         partial_q  <= '0;
         byte_idx_q <= '0;
      end else begin
         partial_q  <= partial_d;
         byte_idx_q <= byte_idx_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: header byte N, then N little-endian words written to the
// instruction memory at byte addresses 0,4,8,... while the core is held.
// Build option IMEM_LOADER_CSUM_EN adds a trailing XOR checksum byte.
//
// Handshake: a byte moves on the rising edge where in_valid && in_ready; in_ready
// depends only on state, and upstream keeps in_data stable while it waits.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH,
   parameter int AW    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_hold,
   output state_e            dbg_state
);

   localparam int IDX_W = $clog2(DEPTH);

   state_e            state_q;
   logic [IDX_W-1:0]  word_idx_q;
   logic [BYTE_W-1:0] count_q;
   logic              done_q, err_q, busy_q, cpu_hold_q;
   logic              mem_we_q;
   logic [AW-1:0]     mem_addr_q;
   logic [WORD_W-1:0] mem_wdata_q;
`ifdef IMEM_LOADER_CSUM_EN
   logic [BYTE_W-1:0] csum_q;
`endif

   logic              accept;
   logic              last_word;
   logic [WORD_W-1:0] pk_word;
   logic              pk_word_valid;

   // Ready is a pure function of state so upstream never sees a combinational loop.
   always_comb begin
      in_ready = (state_q == HDR) || (state_q == DATA);
`ifdef IMEM_LOADER_CSUM_EN
      if (state_q == CSUM) in_ready = 1'b1;
`endif
   end

   assign accept    = in_valid && in_ready;
   assign last_word = ({{(BYTE_W-IDX_W){1'b0}}, word_idx_q} == (count_q - 8'd1));

   // Packer only sees DATA bytes and is flushed in every other state.
   imem_loader_byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (state_q != DATA),
      .byte_valid_i (accept && (state_q == DATA)),
      .byte_i       (in_data),
      .word_o       (pk_word),
      .word_valid_o (pk_word_valid)
   );

   // Loader FSM with registered status and memory write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         word_idx_q  <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         cpu_hold_q  <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= HDR;
                  err_q      <= 1'b0;
                  busy_q     <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                  csum_q     <= '0;
`endif
               end
            end
            HDR: begin
               if (accept) begin
                  word_idx_q <= '0;
                  count_q    <= in_data;
                  if (in_data == '0) begin
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                     busy_q     <= 1'b0;
                     cpu_hold_q <= 1'b0;
                  end else if (in_data > BYTE_W'(DEPTH)) begin
                     state_q <= IDLE;
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
`ifdef IMEM_LOADER_CSUM_EN
                  csum_q <= csum_q ^ in_data;
`endif
                  if (pk_word_valid) begin
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= AW'({word_idx_q, 2'b00});
                     mem_wdata_q <= pk_word;
                     if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_q    <= CSUM;
`else
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        cpu_hold_q <= 1'b0;
`endif
                     end else begin
                        word_idx_q <= word_idx_q + 1'b1;
                     end
                  end
               end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
               if (accept) begin
                  busy_q <= 1'b0;
                  if (in_data == csum_q) begin
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                     cpu_hold_q <= 1'b0;
                  end else begin
                     // Image is untrusted: keep the core held.
                     state_q <= IDLE;
                     err_q   <= 1'b1;
                  end
               end
            end
`endif
            DONE: begin
               if (start) begin
                  state_q    <= HDR;
                  done_q     <= 1'b0;
                  err_q      <= 1'b0;
                  busy_q     <= 1'b1;
                  cpu_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                  csum_q     <= '0;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign cpu_hold  = cpu_hold_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;
   import imem_loader_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, mem_we, busy, done, err, cpu_hold;
   logic [31:0] mem_addr, mem_wdata;
   state_e      dbg_state;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;
   int          writes_seen = 0;
   logic [31:0] last_addr = '0;
   logic [31:0] prog[64];
   logic [7:0]  xor_acc;
   bit          gaps_en = 1'b0;
   int          w0;

   imem_loader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .cpu_hold  (cpu_hold),
      .dbg_state (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // hard stop in case a wait escapes its bound
   initial begin
      #1000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // scoreboard: every write pulse must match the head of the expected queue
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         writes_seen++;
         last_addr = mem_addr;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", mem_addr, mon_e[63:32]);
            chk("wr_data", mem_wdata, mon_e[31:0]);
         end
      end
   end

   // driver tasks (called at a falling edge)
   task automatic send_byte(input logic [7:0] b);
      int n;
      if (gaps_en) repeat ($urandom_range(0, 3)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic send_word(input int idx, input logic [31:0] w);
      exp_q.push_back({32'(idx * 4), w});
      for (int i = 0; i < 4; i++) begin
         xor_acc = xor_acc ^ w[8*i +: 8];
         send_byte(w[8*i +: 8]);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_image(input string tag);
`ifdef IMEM_LOADER_CSUM_EN
      send_byte(xor_acc);
`endif
      repeat (2) @(negedge clk);
      chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic run_load(input string tag, input int n);
      pulse_start();
      xor_acc = 8'h00;
      send_byte(8'(n));
      for (int i = 0; i < n; i++) send_word(i, prog[i]);
      finish_image(tag);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      for (int i = 0; i < 64; i++) prog[i] = $urandom;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);

      // single word: lw x1,0(x0)
      prog[0] = 32'h0000_2083;
      w0 = writes_seen;
      run_load("one_word", 1);
      chk("one_word_count", 32'(writes_seen - w0), 32'd1);
      chk("one_word_addr_hold", mem_addr, 32'd0);
      chk("one_word_data_hold", mem_wdata, 32'h0000_2083);
      chk("done_ready_low", {31'd0, in_ready}, 32'd0);

      // 13 words with random valid gaps
      for (int i = 0; i < 64; i++) prog[i] = $urandom;
      gaps_en = 1'b1;
      w0 = writes_seen;
      run_load("thirteen", 13);
      chk("thirteen_count", 32'(writes_seen - w0), 32'd13);
      chk("thirteen_last", last_addr, 32'd48);
      gaps_en = 1'b0;

      // full memory
      w0 = writes_seen;
      run_load("full", 64);
      chk("full_count", 32'(writes_seen - w0), 32'd64);
      chk("full_last", last_addr, 32'd252);

      // oversize header
      w0 = writes_seen;
      pulse_start();
      chk("start_clears_done", {31'd0, done}, 32'd0);
      chk("start_busy", {31'd0, busy}, 32'd1);
      send_byte(8'h41);
      chk("big_err", {31'd0, err}, 32'd1);
      chk("big_busy", {31'd0, busy}, 32'd0);
      chk("big_done", {31'd0, done}, 32'd0);
      chk("big_hold", {31'd0, cpu_hold}, 32'd1);
      repeat (3) @(negedge clk);
      chk("big_no_writes", 32'(writes_seen - w0), 32'd0);
      chk("big_ready_low", {31'd0, in_ready}, 32'd0);

      // empty image: err clears on start, done one cycle after header
      pulse_start();
      chk("restart_err_clear", {31'd0, err}, 32'd0);
      send_byte(8'h00);
      chk("empty_done", {31'd0, done}, 32'd1);
      chk("empty_hold", {31'd0, cpu_hold}, 32'd0);
      repeat (3) @(negedge clk);
      chk("empty_no_writes", 32'(writes_seen - w0), 32'd0);

      // start while busy is ignored
      for (int i = 0; i < 64; i++) prog[i] = $urandom;
      w0 = writes_seen;
      pulse_start();
      xor_acc = 8'h00;
      send_byte(8'd4);
      send_word(0, prog[0]);
      send_byte(prog[1][7:0]);
      pulse_start();
      chk("mid_start_busy", {31'd0, busy}, 32'd1);
      chk("mid_start_state", 32'(dbg_state), 32'(DATA));
      exp_q.push_back({32'd4, prog[1]});
      xor_acc = xor_acc ^ prog[1][7:0];
      for (int i = 1; i < 4; i++) begin
         xor_acc = xor_acc ^ prog[1][8*i +: 8];
         send_byte(prog[1][8*i +: 8]);
      end
      send_word(2, prog[2]);
      send_word(3, prog[3]);
      finish_image("mid_start");
      chk("mid_start_count", 32'(writes_seen - w0), 32'd4);

      // reset after two bytes of word 5
      w0 = writes_seen;
      pulse_start();
      xor_acc = 8'h00;
      send_byte(8'd8);
      for (int i = 0; i < 5; i++) send_word(i, prog[i]);
      send_byte(8'hAA);
      send_byte(8'h55);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_state", 32'(dbg_state), 32'(IDLE));
      chk("midrst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      repeat (3) @(negedge clk);
      chk("midrst_count", 32'(writes_seen - w0), 32'd5);
      chk("midrst_queue", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < 64; i++) prog[i] = $urandom;
      run_load("after_rst", 8);

`ifdef IMEM_LOADER_CSUM_EN
      // wrong checksum byte
      pulse_start();
      xor_acc = 8'h00;
      send_byte(8'd2);
      send_word(0, prog[0]);
      send_word(1, prog[1]);
      send_byte(xor_acc ^ 8'h5A);
      chk("csum_bad_err", {31'd0, err}, 32'd1);
      chk("csum_bad_done", {31'd0, done}, 32'd0);
      chk("csum_bad_hold", {31'd0, cpu_hold}, 32'd1);
      chk("csum_bad_state", 32'(dbg_state), 32'(IDLE));
      repeat (2) @(negedge clk);
      chk("csum_bad_queue", 32'(exp_q.size()), 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the processor's 64-word instruction memory.
- Accepts a byte stream over a valid/ready handshake (driven by a UART receiver or testbench).
- Assembles little-endian 32-bit instruction words and drives the memory write port.
- Holds the pipeline stalled (cpu_hold) until a complete image is loaded, replacing hard-coded initial blocks for test programs.

Parameters:
- DEPTH, 64, number of 32-bit instruction words in the target memory
- AW, 32, width of mem_addr (byte address; memory indexes by addr/4)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: begin a new load
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable (one-cycle pulse per word)
- mem_addr  out  AW  byte address of word, always a multiple of 4
- mem_wdata  out  32  instruction word
- busy  out  1  load in progress
- done  out  1  image loaded; stays high until next start or rst
- err  out  1  header error on last load; sticky until next start or rst
- cpu_hold  out  1  stall/reset request to the core; high in every state except DONE

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - State = IDLE.
  - All outputs 0 except cpu_hold = 1.
  - Counters and partial word cleared.
- Handshake:
  - A byte transfers on the rising clk edge where in_valid && in_ready.
  - in_ready is combinational from state: 1 only in HDR and DATA (and CSUM when enabled).
  - The upstream holds in_data stable while in_valid && !in_ready.
- States:
  - IDLE: start → HDR. Other inputs ignored.
  - HDR: accept one byte N = word count.
    - N == 0 → DONE with no writes.
    - N > DEPTH → err = 1, → IDLE (no writes).
    - Else → DATA, word_idx = 0, byte_idx = 0.
  - DATA: each accepted byte is placed at bits [8*byte_idx+7 : 8*byte_idx]; byte_idx wraps 3→0.
    - On the 4th byte: on the next cycle mem_we = 1, mem_addr = word_idx*4, mem_wdata = assembled word, and word_idx increments.
    - Write latency is exactly 1 cycle after the 4th byte is accepted.
    - After word N-1 is accepted → DONE (or CSUM when enabled). The final mem_we pulse is issued in the same cycle as entry to DONE.
  - DONE: done = 1, cpu_hold = 0. start → HDR, clearing done and err.
- busy = 1 in HDR, DATA and CSUM.
- start is ignored while busy.
- mem_addr/mem_wdata hold their last values when mem_we = 0.
- Gaps in in_valid of any length are tolerated; no timeout.
- The last word slot is DEPTH-1 (byte address 252 for DEPTH = 64); word_idx never exceeds N-1.
- rst mid-load: returns to IDLE, discards the partial word, cpu_hold = 1. Words already written stay in memory (no clearing).

Optional Feature:
- Macro: IMEM_LOADER_CSUM_EN.
- Defined: after the last data byte, state CSUM accepts one byte C.
  - C is compared with the XOR of all data bytes.
  - Match → DONE.
  - Mismatch → err = 1, → IDLE, with done = 0 and cpu_hold = 1 (the memory contents are untrusted).
  - The XOR accumulator is cleared on entry to HDR.
- Undefined: no CSUM state and no accumulator; DATA goes directly to DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE, HDR, DATA, CSUM, DONE)
  - IMEM_DEPTH = 64
  - BYTE_W = 8
  - WORD_W = 32
- One sub-module is natural: byte_packer (4-byte little-endian shift/assemble, with word_valid pulse).
- The FSM, counters and write port stay in imem_loader.

Test Plan:
- Load 1 word, bytes 0x83,0x20,0x00,0x00 after header 0x01 → one mem_we, mem_addr = 0, mem_wdata = 0x00002083 (lw x1,0(x0)); done = 1, cpu_hold = 0.
- Header 0x0D then 13 program words with random in_valid gaps → 13 pulses at addresses 0..48, data in order, no extra writes.
- Header 0x40 (64 words) → last write at mem_addr = 252; header 0x41 → err = 1, zero writes, cpu_hold stays 1.
- Header 0x00 → done the cycle after the header, no mem_we; start pulsed while busy mid-image → ignored, image completes.
- rst asserted after 2 bytes of word 5 → IDLE, no write for word 5, cpu_hold = 1; a fresh start and full load then succeeds.
- CSUM_EN: correct XOR byte → done; wrong byte → err = 1, done = 0, cpu_hold = 1.
